// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and queue entry type for the instruction fetch stage.
package fetch_pkg;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h8002_0000;
   localparam logic [1:0]  MEM_ACCESS_WORD  = 2'b00;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction queue with flush, occupancy count and simultaneous push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  fetch_entry_t               din_i,
   input  logic                       pop_i,
   output fetch_entry_t               dout_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   fetch_entry_t   mem_q [DEPTH];
   logic [AW-1:0]  wr_q, rd_q;
   logic [AW:0]    count_q;
   assign dout_o  = mem_q[rd_q];
   assign count_o = count_q;
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_i) rd_q <= rd_q + 1'b1;
         count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-word reads and queueing {pc, insn} for decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fault and halts fetch.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_addr,
   output logic        mem_enable,
   output logic        mem_rd_wr,
   output logic [1:0]  mem_access_size,
   output logic [31:0] mem_data_in,
   input  logic        mem_busy,
   input  logic [31:0] mem_data_out,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [31:0] insn,
   output logic [31:0] insn_pc,
   output logic        fault
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [31:0]  fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d, target_pc;
   logic         inflight_q, inflight_d, fault_q, fault_d, issue, push, pop;
   logic [CW-1:0] count;
   fetch_entry_t resp, head;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign target_pc = redirect_pc;
   assign fault_d   = fault_q | (redirect & (redirect_pc[1:0] != 2'b00));
`else
   assign target_pc = redirect_pc & 32'hFFFF_FFFC;
   assign fault_d   = 1'b0;
`endif
   // Count plus the outstanding read reserves a queue slot for every issued word.
   assign issue = !rst && !redirect && !mem_busy && !fault_q &&
                  (count + CW'(inflight_q)) < CW'(FIFO_DEPTH);
   // Redirect flushes the queue and drops the response arriving on the same edge.
   assign push       = inflight_q & ~redirect;
   assign pop        = insn_valid & insn_ready & ~redirect;
   assign resp       = '{pc: inflight_pc_q, insn: mem_data_out};
   assign insn_valid = count != '0;
   assign insn       = head.insn;
   assign insn_pc    = head.pc;
   assign mem_addr        = fetch_pc_q;
   assign mem_enable      = issue;
   assign mem_rd_wr       = 1'b1;
   assign mem_access_size = MEM_ACCESS_WORD;
   assign mem_data_in     = '0;
   assign fault           = fault_q;
   always_comb begin
      fetch_pc_d    = redirect ? target_pc : issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= PC_RESET;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         fault_q       <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         fault_q       <= fault_d;
      end
   end
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect),
      .push_i  (push),
      .din_i   (resp),
      .pop_i   (pop),
      .dout_o  (head),
      .count_o (count)
   );
endmodule
